maxpool2d_2x2_param: RTL
========================

MAXPOOL2D_2X2_PARAM -- requirements
Module: maxpool2d_2x2_param

Interface
REQ-001 SHALL have parameter DATA_W, default 4: unsigned activation width.
REQ-002 SHALL have parameter IN_H, default 8: input feature-map rows (2..64).
REQ-003 SHALL have parameter IN_W, default 8: input feature-map columns (2..64).
REQ-004 SHALL have parameter CHANNELS, default 128: channel count (1..512).
REQ-005 SHALL have parameter PACK, default 8: activations per 32-bit output word; PACK*DATA_W SHALL equal 32.
REQ-006 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-007 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: one-cycle request to run the layer.
REQ-009 SHALL have port src_start, output, 1: one-cycle start pulse to the upstream layer.
REQ-010 SHALL have port src_done, input, 1: upstream result ready.
REQ-011 SHALL have port src_rd_addr, output, 32: upstream activation index, ch*IN_H*IN_W + r*IN_W + c.
REQ-012 SHALL have port src_rd_data, input, DATA_W: upstream data, valid one cycle after src_rd_addr.
REQ-013 SHALL have port read_addr, input, 32: output activation index, ch*OH*OW + r*OW + c.
REQ-014 SHALL have port read_data, output, DATA_W: output activation, valid one cycle after read_addr.
REQ-015 SHALL have port busy, output, 1: high from accepted start until done.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-017 SHALL use OH = IN_H/2 and OW = IN_W/2 (floor); an odd last row/column SHALL be ignored.
REQ-018 SHALL use the FSM IDLE -> SRC_START -> SRC_WAIT -> FETCH -> REDUCE -> (PACK | WRITE) -> ... -> DONE -> IDLE.
REQ-019 In IDLE, start SHALL cause src_start=1 next cycle and busy=1; start while busy SHALL be ignored.
REQ-020 SRC_WAIT SHALL hold until src_done=1; src_done in any other state SHALL be ignored.
REQ-021 FETCH SHALL issue the window addresses (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1) on 4 consecutive cycles, with data captured pipelined one cycle later (5 cycles per window).
REQ-022 REDUCE SHALL output the unsigned maximum of the 4 samples; ties are irrelevant.
REQ-023 Each result SHALL go into lane k = (linear output index mod PACK), lane 0 at bits [31:32-DATA_W].
REQ-024 When lane PACK-1 is filled, or on the final window, WRITE SHALL store the word at word address index/PACK and clear the pack register; unused lanes of a final partial word SHALL be 0.
REQ-025 Window order SHALL be column fastest, then row, then channel; the last window (CHANNELS-1, OH-1, OW-1) SHALL lead to DONE after its WRITE.
REQ-026 DONE SHALL pulse done=1 for one cycle, drop busy, and return to IDLE; output memory SHALL keep its contents until the next run overwrites them.
REQ-027 read_data SHALL return lane read_addr mod PACK of word read_addr/PACK with 1-cycle latency, at any time; a read of a word written in the same cycle returns the old data.
REQ-028 read_addr beyond CHANNELS*OH*OW SHALL return an undefined but X-free value.

Reset
REQ-029 On resetn=0: state=IDLE, done=0, busy=0, src_start=0, src_rd_addr=0, counters and pack register 0.
REQ-030 Reset mid-run SHALL abort with no further writes and no done pulse; output memory contents are not cleared.

Configuration
REQ-031 With MAXPOOL_AVG_MODE_EN defined, an input port avg_mode (1 bit, sampled at accepted start) SHALL select average pooling: (sum of 4 + 2) >> 2, sum width DATA_W+2, result saturated to DATA_W bits.
REQ-032 Without MAXPOOL_AVG_MODE_EN, the port SHALL NOT exist and only max pooling SHALL be built.

Structure
REQ-033 A package maxpool_pkg SHALL hold the FSM state enum and the OUT_WORD_W=32 constant.
REQ-034 Sub-module pool_window_reduce SHALL be a combinational 4-to-1 max (or avg) reducer; the output memory SHALL be an inferred simple dual-port RAM of ceil(CHANNELS*OH*OW/PACK) words.

Verification
REQ-035 Defaults, ch0 window {3,9,1,2} -> read_addr 0 returns 9 two cycles after done plus one.
REQ-036 Ramp input value = index mod 16 -> every output equals the max of its window; done arrives exactly once.
REQ-037 IN_H=IN_W=5, CHANNELS=3 -> OH=OW=2, 12 outputs, last word lanes 4..7 read 0.
REQ-038 start repeated while busy, src_done held early -> single src_start pulse, single done.
REQ-039 resetn low during FETCH of channel 40 -> busy=0 next cycle, no done, restart completes correctly.
REQ-040 With MAXPOOL_AVG_MODE_EN and avg_mode=1, window {15,15,15,14} -> 15; {1,2,2,2} -> 2.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared FSM encoding and output word width for the 2x2 pooling layer.
package maxpool_pkg;
  localparam int OUT_WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC_START,
    S_SRC_WAIT,
    S_FETCH,
    S_REDUCE,
    S_PACK,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/pool_window_reduce.sv
// Combinational 4-to-1 window reducer: unsigned max, plus rounded and saturated
// average when MAXPOOL_AVG_MODE_EN is defined.
module pool_window_reduce #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] s0,
  input  logic [DATA_W-1:0] s1,
  input  logic [DATA_W-1:0] s2,
  input  logic [DATA_W-1:0] s3,
`ifdef MAXPOOL_AVG_MODE_EN
  input  logic              avg,
`endif
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] m01, m23, mx;

  assign m01 = (s0 > s1) ? s0 : s1;
  assign m23 = (s2 > s3) ? s2 : s3;
  assign mx  = (m01 > m23) ? m01 : m23;

`ifdef MAXPOOL_AVG_MODE_EN
  logic [DATA_W+1:0] sum, quo;
  logic [DATA_W-1:0] avg_y;

  // Worst case 4*max+2 still fits in DATA_W+2 bits, so the sum cannot wrap.
  assign sum   = {2'b00, s0} + {2'b00, s1} + {2'b00, s2} + {2'b00, s3} + (DATA_W+2)'(2);
  assign quo   = sum >> 2;
  assign avg_y = (|quo[DATA_W+1:DATA_W]) ? '1 : quo[DATA_W-1:0];
  assign y     = avg ? avg_y : mx;
`else
  assign y = mx;
`endif
endmodule

// File: rtl/maxpool2d_2x2_param.sv
// 2x2 stride-2 pooling over a CHW activation map, results packed PACK per 32-bit word.
// Define MAXPOOL_AVG_MODE_EN to add the avg_mode port and average pooling.
module maxpool2d_2x2_param
  import maxpool_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int IN_H     = 8,
  parameter int IN_W     = 8,
  parameter int CHANNELS = 128,
  parameter int PACK     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              src_start,
  input  logic              src_done,
  output logic [31:0]       src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  input  logic [31:0]       read_addr,
  output logic [DATA_W-1:0] read_data,
`ifdef MAXPOOL_AVG_MODE_EN
  input  logic              avg_mode,
`endif
  output logic              busy,
  output logic              done
);
  localparam int OH    = IN_H / 2;
  localparam int OW    = IN_W / 2;
  localparam int NOUT  = CHANNELS * OH * OW;
  localparam int DEPTH = (NOUT + PACK - 1) / PACK;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;

  state_t                  state;
  logic [31:0]             ch, r, c, out_idx;
  logic [31:0]             ch_nx, r_nx, c_nx;
  logic [1:0]              fcnt;
  logic [DATA_W-1:0]       s0, s1, s2, red_y;
  logic [OUT_WORD_W-1:0]   pack_reg, rd_word;
  logic [OUT_WORD_W-1:0]   mem [DEPTH];
  logic [LW-1:0]           lane, rd_lane;
  logic [MAW-1:0]          waddr;
  logic                    last_win;

  function automatic logic [31:0] win_base(logic [31:0] wch, logic [31:0] wr, logic [31:0] wc);
    return wch * (IN_H * IN_W) + (wr * 2) * IN_W + wc * 2;
  endfunction

  assign last_win = (ch == CHANNELS - 1) && (r == OH - 1) && (c == OW - 1);
  assign c_nx     = (c == OW - 1) ? 32'd0 : c + 32'd1;
  assign r_nx     = (c == OW - 1) ? ((r == OH - 1) ? 32'd0 : r + 32'd1) : r;
  assign ch_nx    = ((c == OW - 1) && (r == OH - 1)) ? ch + 32'd1 : ch;
  assign lane     = LW'(out_idx % PACK);
  assign waddr    = MAW'(out_idx / PACK);

`ifdef MAXPOOL_AVG_MODE_EN
  logic avg_sel;

  always_ff @(posedge clk) begin
    if (!resetn)                        avg_sel <= 1'b0;
    else if (state == S_IDLE && start)  avg_sel <= avg_mode;
  end
`endif

  // Fourth sample is taken straight off the upstream bus in REDUCE.
  pool_window_reduce #(.DATA_W(DATA_W)) u_reduce (
    .s0  (s0),
    .s1  (s1),
    .s2  (s2),
    .s3  (src_rd_data),
`ifdef MAXPOOL_AVG_MODE_EN
    .avg (avg_sel),
`endif
    .y   (red_y)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      src_start   <= 1'b0;
      src_rd_addr <= '0;
      ch          <= '0;
      r           <= '0;
      c           <= '0;
      out_idx     <= '0;
      fcnt        <= '0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      pack_reg    <= '0;
    end else begin
      done      <= 1'b0;
      src_start <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state     <= S_SRC_START;
          busy      <= 1'b1;
          src_start <= 1'b1;
          ch        <= '0;
          r         <= '0;
          c         <= '0;
          out_idx   <= '0;
          pack_reg  <= '0;
        end
        S_SRC_START: state <= S_SRC_WAIT;
        S_SRC_WAIT: if (src_done) begin
          state       <= S_FETCH;
          fcnt        <= '0;
          src_rd_addr <= win_base(ch, r, c);
        end
        S_FETCH: begin
          // Data lags the address by one cycle, so sample k lands at fcnt k+1.
          case (fcnt)
            2'd1:    s0 <= src_rd_data;
            2'd2:    s1 <= src_rd_data;
            2'd3:    s2 <= src_rd_data;
            default: ;
          endcase
          if (fcnt == 2'd3) state <= S_REDUCE;
          else begin
            fcnt        <= fcnt + 2'd1;
            src_rd_addr <= src_rd_addr + ((fcnt == 2'd1) ? 32'(IN_W - 1) : 32'd1);
          end
        end
        S_REDUCE: begin
          pack_reg[OUT_WORD_W-1 - int'(lane)*DATA_W -: DATA_W] <= red_y;
          state <= (lane == LW'(PACK - 1) || last_win) ? S_WRITE : S_PACK;
        end
        S_PACK, S_WRITE: begin
          if (state == S_WRITE) pack_reg <= '0;
          if (state == S_WRITE && last_win) state <= S_DONE;
          else begin
            state       <= S_FETCH;
            fcnt        <= '0;
            ch          <= ch_nx;
            r           <= r_nx;
            c           <= c_nx;
            out_idx     <= out_idx + 32'd1;
            src_rd_addr <= win_base(ch_nx, r_nx, c_nx);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output RAM: write port from the FSM, read port free-running for the consumer.
  always_ff @(posedge clk) begin
    if (resetn && state == S_WRITE) mem[waddr] <= pack_reg;
  end

  always_ff @(posedge clk) begin
    if ((read_addr / PACK) < DEPTH) rd_word <= mem[MAW'(read_addr / PACK)];
    else                            rd_word <= '0;
    rd_lane <= LW'(read_addr % PACK);
  end

  assign read_data = rd_word[OUT_WORD_W-1 - int'(rd_lane)*DATA_W -: DATA_W];
endmodule
